instr_encode_loader: RTL and testbench

INSTR_ENCODE_LOADER -- requirements
Module: instr_encode_loader

---
 rtl/instr_encode_loader.sv | 154 +++++++++++++++
 tb/tb_instr_encode_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encode_loader.sv
// ----------------------------------------------------------------------------
// instr_encode_loader
//
// Purpose: accepts decoded instruction fields one at a time from a producer
// over a valid/ready handshake. Each legal instruction is encoded into a
// 32-bit MIPS-style word and written to sequential instruction-memory
// addresses, starting at 0. Illegal ops raise a sticky error flag and are
// not written. Loading ends on the instruction marked 'last', or when the
// top memory address has been written. After that the block idles in DONE
// until reset.
//
// Ports:
//   clk, reset            single clock; synchronous active-high reset
//   in_valid / in_ready   producer handshake; fields sampled on transfer
//   op_sel                0=R 1=ori 2=lw 3=sw 4=beq 5=lui 6=jal 7=illegal
//   rs, rt, rd, funct     register fields and R-type function code
//   imm, target           I-type immediate and J-type target
//   last                  marks the final instruction of a program
//   im_we/im_addr/im_wdata  instruction-memory write port (qualify with im_we)
//   count                 number of words written
//   done                  load complete
//   err                   sticky illegal-op flag
// ----------------------------------------------------------------------------
module instr_encode_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              last,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_word;
  logic              r_last;
  logic              r_err;
  logic [31:0]       w_word;
  logic              w_illegal;
  logic              w_xfer;

  // Instruction encoder.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves it unassigned and no latch is inferred.
  always_comb begin
    w_word    = 32'h0;
    w_illegal = 1'b0;
    case (op_sel)
      3'd0:    w_word = {6'b000000, rs, rt, rd, 5'b00000, funct};
      3'd1:    w_word = {6'b001101, rs, rt, imm};
      3'd2:    w_word = {6'b100011, rs, rt, imm};
      3'd3:    w_word = {6'b101011, rs, rt, imm};
      3'd4:    w_word = {6'b000100, rs, rt, imm};
      3'd5:    w_word = {6'b001111, 5'b00000, rt, imm}; // lui has no source reg
      3'd6:    w_word = {6'b000011, target};
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_xfer = in_valid && in_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake/write-enable outputs. Reset gates in_ready and
  // im_we combinationally so a reset landing on a WRITE cycle suppresses
  // the memory write in that same cycle.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    im_we    = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = !reset;
        if (w_xfer) begin
          if (w_illegal) w_next = last ? S_DONE : S_IDLE;
          else           w_next = S_WRITE;
        end
      end
      S_WRITE: begin
        im_we  = !reset;
        // Writing the top address ends the load: ptr must never wrap.
        w_next = (r_last || (r_ptr == PTR_MAX)) ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latched word, write pointer, counters and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_addr  <= '0;
      r_count <= '0;
      r_word  <= 32'h0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_xfer) begin
        if (w_illegal) begin
          r_err <= 1'b1;
        end else begin
          r_word <= w_word;
          r_last <= last;
          r_addr <= r_ptr;   // separate copy keeps im_addr stable after ptr moves
        end
      end
      if (im_we) begin
        r_count <= r_count + 1'b1;
        if (r_ptr != PTR_MAX) r_ptr <= r_ptr + 1'b1;
      end
    end
  end

  assign im_addr  = r_addr;
  assign im_wdata = r_word;
  assign count    = r_count;
  assign err      = r_err;

endmodule

// File: tb/tb_instr_encode_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_encode_loader
//
// Directed bench for instr_encode_loader. Instance dut_a uses the default
// ADDR_W=10. Instance dut_b uses ADDR_W=2 to exercise the full-memory stop.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_instr_encode_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // ---- dut_a signals (ADDR_W=10) ----
  logic        a_reset, a_in_valid, a_in_ready, a_last;
  logic [2:0]  a_op_sel;
  logic [4:0]  a_rs, a_rt, a_rd;
  logic [5:0]  a_funct;
  logic [15:0] a_imm;
  logic [25:0] a_target;
  logic        a_im_we, a_done, a_err;
  logic [9:0]  a_im_addr;
  logic [31:0] a_im_wdata;
  logic [10:0] a_count;

  // ---- dut_b signals (ADDR_W=2) ----
  logic        b_reset, b_in_valid, b_in_ready, b_last;
  logic [2:0]  b_op_sel;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [5:0]  b_funct;
  logic [15:0] b_imm;
  logic [25:0] b_target;
  logic        b_im_we, b_done, b_err;
  logic [1:0]  b_im_addr;
  logic [31:0] b_im_wdata;
  logic [2:0]  b_count;

  instr_encode_loader #(.ADDR_W(10)) dut_a (
    .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .op_sel(a_op_sel), .rs(a_rs), .rt(a_rt), .rd(a_rd), .funct(a_funct),
    .imm(a_imm), .target(a_target), .last(a_last),
    .im_we(a_im_we), .im_addr(a_im_addr), .im_wdata(a_im_wdata),
    .count(a_count), .done(a_done), .err(a_err)
  );

  instr_encode_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .op_sel(b_op_sel), .rs(b_rs), .rt(b_rt), .rd(b_rd), .funct(b_funct),
    .imm(b_imm), .target(b_target), .last(b_last),
    .im_we(b_im_we), .im_addr(b_im_addr), .im_wdata(b_im_wdata),
    .count(b_count), .done(b_done), .err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [4:0] rs_v, input logic [4:0] rt_v,
                         input logic [4:0] rd_v, input logic [5:0] fn_v, input logic [15:0] imm_v,
                         input logic [25:0] tgt_v, input logic last_v);
    a_op_sel   = op;
    a_rs       = rs_v;
    a_rt       = rt_v;
    a_rd       = rd_v;
    a_funct    = fn_v;
    a_imm      = imm_v;
    a_target   = tgt_v;
    a_last     = last_v;
    a_in_valid = 1'b1;
  endtask

  // Reset for one edge; returns at posedge+1 with reset released.
  task automatic reset_a();
    a_reset    = 1'b1;
    a_in_valid = 1'b0;
    step();
    a_reset = 1'b0;
  endtask

  // One write cycle on dut_a, sampled in the WRITE cycle.
  task automatic expect_write_a(input string tag, input logic [9:0] addr, input logic [31:0] data);
    sample();
    check({tag, "_we"},    {31'b0, a_im_we},    32'd1);
    check({tag, "_addr"},  {22'b0, a_im_addr},  {22'b0, addr});
    check({tag, "_data"},  a_im_wdata,          data);
    check({tag, "_ready"}, {31'b0, a_in_ready}, 32'd0);
  endtask

  initial begin
    a_reset = 1'b1; a_in_valid = 1'b0; a_last = 1'b0; a_op_sel = 3'd0;
    a_rs = '0; a_rt = '0; a_rd = '0; a_funct = '0; a_imm = '0; a_target = '0;
    b_reset = 1'b1; b_in_valid = 1'b0; b_last = 1'b0; b_op_sel = 3'd1;
    b_rs = '0; b_rt = 5'd8; b_rd = '0; b_funct = '0; b_imm = '0; b_target = '0;

    // ---- reset state ----
    step();
    step();
    sample();
    check("rst_ready", {31'b0, a_in_ready}, 32'd0);
    check("rst_we",    {31'b0, a_im_we},    32'd0);
    check("rst_count", {21'b0, a_count},    32'd0);
    check("rst_done",  {31'b0, a_done},     32'd0);
    check("rst_err",   {31'b0, a_err},      32'd0);
    step();
    a_reset = 1'b0;
    sample();
    check("post_rst_ready", {31'b0, a_in_ready}, 32'd1);

    // ---- ori rs=0 rt=8 imm=0x1234 ----
    drive_a(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0);
    step();
    a_in_valid = 1'b0;
    expect_write_a("ori", 10'd0, 32'h3408_1234);
    step();
    sample();
    check("ori_count", {21'b0, a_count},    32'd1);
    check("ori_ready", {31'b0, a_in_ready}, 32'd1);
    check("ori_we_off", {31'b0, a_im_we},   32'd0);

    // ---- R-type then lui (rs forced to 0) ----
    reset_a();
    drive_a(3'd0, 5'd8, 5'd9, 5'd10, 6'h21, 16'h0, 26'd0, 1'b0);
    step();
    a_in_valid = 1'b0;
    expect_write_a("rtype", 10'd0, 32'h0109_5021);
    step();
    drive_a(3'd5, 5'd5, 5'd1, 5'd0, 6'd0, 16'h8000, 26'd0, 1'b0);
    step();
    a_in_valid = 1'b0;
    expect_write_a("lui", 10'd1, 32'h3C01_8000);
    step();
    sample();
    check("rl_count",     {21'b0, a_count},   32'd2);
    check("hold_addr",    {22'b0, a_im_addr}, 32'd1);
    check("hold_wdata",   a_im_wdata,         32'h3C01_8000);

    // ---- jal with last=1 -> DONE, later inputs ignored ----
    drive_a(3'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h000_0C00, 1'b1);
    step();
    a_in_valid = 1'b0;
    expect_write_a("jal", 10'd2, 32'h0C00_0C00);
    step();
    sample();
    check("jal_done",  {31'b0, a_done},     32'd1);
    check("jal_ready", {31'b0, a_in_ready}, 32'd0);
    check("jal_count", {21'b0, a_count},    32'd3);
    drive_a(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h5555, 26'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      sample();
      check("done_no_we",  {31'b0, a_im_we},  32'd0);
      check("done_sticky", {31'b0, a_done},   32'd1);
      check("done_count",  {21'b0, a_count},  32'd3);
    end
    a_in_valid = 1'b0;

    // ---- illegal op then beq ----
    reset_a();
    drive_a(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'd0, 1'b0);
    step();
    a_in_valid = 1'b0;
    sample();
    check("ill_we",    {31'b0, a_im_we},    32'd0);
    check("ill_err",   {31'b0, a_err},      32'd1);
    check("ill_ready", {31'b0, a_in_ready}, 32'd1);
    check("ill_count", {21'b0, a_count},    32'd0);
    drive_a(3'd4, 5'd1, 5'd2, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b0);
    step();
    a_in_valid = 1'b0;
    expect_write_a("beq", 10'd0, 32'h1022_FFFF);
    step();
    sample();
    check("beq_count", {21'b0, a_count}, 32'd1);
    check("beq_err",   {31'b0, a_err},   32'd1);
    // illegal op with last=1 ends the load without writing
    drive_a(3'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'd0, 1'b1);
    step();
    a_in_valid = 1'b0;
    sample();
    check("ill_last_done",  {31'b0, a_done},  32'd1);
    check("ill_last_we",    {31'b0, a_im_we}, 32'd0);
    check("ill_last_count", {21'b0, a_count}, 32'd1);

    // ---- reset asserted during WRITE ----
    reset_a();
    sample();
    check("err_cleared", {31'b0, a_err}, 32'd0);
    drive_a(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0);
    step();
    a_in_valid = 1'b0;
    a_reset    = 1'b1;
    sample();
    check("rstw_we",    {31'b0, a_im_we},    32'd0);
    check("rstw_ready", {31'b0, a_in_ready}, 32'd0);
    step();
    a_reset = 1'b0;
    sample();
    check("rstw_count", {21'b0, a_count},    32'd0);
    check("rstw_ready2", {31'b0, a_in_ready}, 32'd1);
    drive_a(3'd2, 5'd3, 5'd4, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b0);
    step();
    a_in_valid = 1'b0;
    expect_write_a("lw_after_rst", 10'd0, 32'h8C64_0010);

    // ---- ADDR_W=2: memory fills after four writes ----
    b_reset = 1'b1;
    step();
    b_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_imm      = 16'(i);
      b_in_valid = 1'b1;
      sample();
      check("full_ready", {31'b0, b_in_ready}, 32'd1);
      step();
      b_in_valid = 1'b0;
      sample();
      check("full_we",   {31'b0, b_im_we},   32'd1);
      check("full_addr", {30'b0, b_im_addr}, 32'(i));
      check("full_data", b_im_wdata,         32'h3408_0000 | 32'(i));
      step();
    end
    b_imm      = 16'h00AA;
    b_in_valid = 1'b1;
    sample();
    check("full_fifth_ready", {31'b0, b_in_ready}, 32'd0);
    check("full_done",        {31'b0, b_done},     32'd1);
    check("full_count",       {29'b0, b_count},    32'd4);
    step();
    sample();
    check("full_fifth_we",    {31'b0, b_im_we},    32'd0);
    check("full_count_hold",  {29'b0, b_count},    32'd4);
    check("full_addr_hold",   {30'b0, b_im_addr},  32'd3);
    b_in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
